// File: rtl/alu128_arbiter.sv
// alu128_arbiter: round-robin arbiter that shares one combinational 128-bit ALU
// (midterm128bit) among NUM_REQ requesters. The winner's operands are registered,
// the ALU is evaluated from those registers, and the result is returned on a
// valid/ready response channel tagged with the requester index.
// Optional feature macro: ALU128_ARB_STICKY_EN adds per-requester sticky overflow
// bits (sticky_ovf) with per-bit clear (sticky_clr).

// Combinational 128-bit ALU.
// mode=0: opsel 000 add, 001 sub, 010 inc op1, 011 dec op1,
//         100 pass op1, 101 pass op2, 110 shl op1, 111 shr op1
// mode=1: opsel 000 and, 001 or, 010 xor, 011 nand,
//         100 nor, 101 xnor, 110 not op1, 111 not op2
module midterm128bit (
    input  logic [127:0] op1,
    input  logic [127:0] op2,
    input  logic [2:0]   opsel,
    input  logic         mode,
    output logic [127:0] result,
    output logic         c,
    output logic         z,
    output logic         o,
    output logic         s
);

    logic [127:0] b_eff;
    logic         cin;
    logic [128:0] sum;

    // Select the second adder operand and carry-in for the arithmetic ops
    always_comb begin
        b_eff = op2;
        cin   = 1'b0;
        case (opsel[1:0])
            2'b00: begin b_eff = op2;    cin = 1'b0; end
            2'b01: begin b_eff = ~op2;   cin = 1'b1; end
            2'b10: begin b_eff = '0;     cin = 1'b1; end
            default: begin b_eff = '1;   cin = 1'b0; end
        endcase
    end

    assign sum = {1'b0, op1} + {1'b0, b_eff} + {128'd0, cin};

    // Result and flags; z and s always follow the selected result
    always_comb begin
        result = '0;
        c      = 1'b0;
        o      = 1'b0;
        if (!mode) begin
            if (!opsel[2]) begin
                result = sum[127:0];
                c      = sum[128];
                o      = (op1[127] == b_eff[127]) && (sum[127] != op1[127]);
            end else begin
                case (opsel[1:0])
                    2'b00: result = op1;
                    2'b01: result = op2;
                    2'b10: begin result = {op1[126:0], 1'b0}; c = op1[127]; end
                    default: begin result = {1'b0, op1[127:1]}; c = op1[0]; end
                endcase
            end
        end else begin
            case (opsel)
                3'b000: result = op1 & op2;
                3'b001: result = op1 | op2;
                3'b010: result = op1 ^ op2;
                3'b011: result = ~(op1 & op2);
                3'b100: result = ~(op1 | op2);
                3'b101: result = ~(op1 ^ op2);
                3'b110: result = ~op1;
                default: result = ~op2;
            endcase
        end
        z = (result == '0);
        s = result[127];
    end

endmodule

// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; grants round-robin from last_grant+1
// EXEC  | ALU evaluates the operand registers; result/flags captured
// RESP  | response held on rsp_* until rsp_ready
module alu128_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_op1,
    input  logic [NUM_REQ*128-1:0] req_op2,
    input  logic [NUM_REQ*3-1:0]   req_opsel,
    input  logic [NUM_REQ-1:0]     req_mode,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [127:0]           rsp_result,
    output logic [3:0]             rsp_flags
`ifdef ALU128_ARB_STICKY_EN
    ,
    output logic [NUM_REQ-1:0]     sticky_ovf,
    input  logic [NUM_REQ-1:0]     sticky_clr
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t state_q, state_d;

    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] cur_id_q;
    logic [127:0]    op1_q, op2_q;
    logic [2:0]      opsel_q;
    logic            mode_q;

    logic            hi_found, lo_found, grant_found;
    logic [ID_W-1:0] hi_idx, lo_idx, grant_idx;
    logic            accept, capture;

    logic [127:0]    sel_op1, sel_op2;
    logic [2:0]      sel_opsel;
    logic            sel_mode;

    logic [127:0]    alu_result;
    logic            alu_c, alu_z, alu_o, alu_s;

    // Round-robin search: lowest valid index above last_grant, else lowest at or below it
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                if (k > int'(last_grant_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(k);
                end
            end
        end
        grant_found = hi_found | lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_op1   = '0;
        sel_op2   = '0;
        sel_opsel = '0;
        sel_mode  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == grant_idx) begin
                sel_op1   = req_op1[k*128 +: 128];
                sel_op2   = req_op2[k*128 +: 128];
                sel_opsel = req_opsel[k*3 +: 3];
                sel_mode  = req_mode[k];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; ready is masked by reset so a
    // request coinciding with reset never sees a handshake
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found && !reset) begin
                    req_ready = NUM_REQ'(1) << grant_idx;
                    accept    = 1'b1;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand registers and grant bookkeeping, loaded on the request handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            cur_id_q     <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            opsel_q      <= '0;
            mode_q       <= 1'b0;
        end else if (accept) begin
            last_grant_q <= grant_idx;
            cur_id_q     <= grant_idx;
            op1_q        <= sel_op1;
            op2_q        <= sel_op2;
            opsel_q      <= sel_opsel;
            mode_q       <= sel_mode;
        end
    end

    midterm128bit u_alu (
        .op1    (op1_q),
        .op2    (op2_q),
        .opsel  (opsel_q),
        .mode   (mode_q),
        .result (alu_result),
        .c      (alu_c),
        .z      (alu_z),
        .o      (alu_o),
        .s      (alu_s)
    );

    // Response registers, written only while in EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else if (capture) begin
            rsp_id     <= cur_id_q;
            rsp_result <= alu_result;
            rsp_flags  <= {alu_c, alu_z, alu_o, alu_s};
        end
    end

`ifdef ALU128_ARB_STICKY_EN
    logic [NUM_REQ-1:0] sticky_set;

    assign sticky_set = (rsp_valid && rsp_ready && rsp_flags[1]) ?
                        (NUM_REQ'(1) << rsp_id) : '0;

    // Sticky overflow: a set in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_ovf <= '0;
        end else begin
            sticky_ovf <= (sticky_ovf & ~sticky_clr) | sticky_set;
        end
    end
`endif

endmodule

// File: doc/alu128_arbiter.md
# alu128_arbiter

- Shares one combinational 128-bit ALU instance (`midterm128bit`: `op1`, `op2`, `opsel[2:0]`, `mode` in; `result[127:0]` and `c/z/o/s` flags out) among `NUM_REQ` requesters.
- Arbitration is round-robin. The winner's operands are registered, the ALU is evaluated, and the result and flags are captured.
- The result is returned on a single valid/ready response channel tagged with the requester index.
- The block sits between the instruction-issue logic and the ALU.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of `rsp_id`; must not be overridden.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept; at most one bit high per cycle.
- `req_op1`  in  `NUM_REQ*128`  operand 1; requester k occupies bits `[k*128 +: 128]`.
- `req_op2`  in  `NUM_REQ*128`  operand 2, same packing as `req_op1`.
- `req_opsel`  in  `NUM_REQ*3`  ALU opsel; requester k occupies bits `[k*3 +: 3]`.
- `req_mode`  in  `NUM_REQ`  ALU mode per requester.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  `ID_W`  index of the requester owning the response.
- `rsp_result`  out  128  ALU result.
- `rsp_flags`  out  4  `{c, z, o, s}`.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` bit is set, grant index g: the first set bit searching upward (with wrap) from `last_grant+1`.
  - `req_ready[g]=1` combinationally in that same cycle; the handshake completes when `req_valid[g] && req_ready[g]`.
  - On the handshake, capture `op1`/`op2`/`opsel`/`mode` of g into the operand registers, set `last_grant<=g` and `cur_id<=g`, and go to EXEC.
  - With no valid request, stay in IDLE and keep `req_ready` all zero.
- EXEC:
  - The ALU is driven only from the operand registers.
  - Capture `result` and the four flags into the response registers, then go to RESP.
  - `req_ready` is 0.
- RESP:
  - `rsp_valid=1`; `rsp_id`, `rsp_result` and `rsp_flags` are held stable until `rsp_ready=1`.
  - On `rsp_valid && rsp_ready`, go to IDLE. `req_ready` is 0 throughout RESP.
- `req_ready` is never asserted outside IDLE. A requester that drops `req_valid` before being granted loses nothing, and no state changes.
- Operand registers are not cleared after use. Response registers change only in EXEC.
- Arithmetic: widths pass straight through; the block never alters or recomputes flags.

## Timing
- Reset values:
  - state = IDLE; `last_grant = NUM_REQ-1`, so requester 0 has first priority after reset.
  - `req_ready = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_result = 0`, `rsp_flags = 0`; operand registers = 0.
- Latency: request accepted at edge T, EXEC occupies cycle T+1, and `rsp_valid` is high from cycle T+2.
- Throughput: one operation per 3 cycles when `rsp_ready` is held high.
- `reset` asserted in any state returns the block to IDLE on that edge and discards the in-flight operation. No response is produced for it.
- If `reset` and a request handshake occur in the same cycle, reset wins and the request is not accepted.
- A new request can be granted in the cycle after the response handshake, not in the same cycle.

## Configuration
- `ALU128_ARB_STICKY_EN` defined:
  - Adds port `sticky_ovf` (out, `NUM_REQ`) and port `sticky_clr` (in, `NUM_REQ`).
  - On each response handshake with `o=1`, `sticky_ovf[rsp_id]` is set.
  - `sticky_clr[k]` clears bit k. If set and clear hit the same bit in the same cycle, set wins.
  - Reset value is all zero.
- `ALU128_ARB_STICKY_EN` undefined: both ports and all sticky logic are absent. All other behaviour is identical.

## Test plan
- Reset, then assert `req_valid=2'b11` with both requesters loaded with operands -> grant to requester 0 first and requester 1 for the next operation. `rsp_id` sequence is 0, 1.
- Add (opsel=3'b000, mode=0) with op1=128'hFFFF…FFFF, op2=1 -> `rsp_result=0`, c=1, z=1, `rsp_valid` exactly 2 cycles after acceptance.
- Hold `rsp_ready=0` for 5 cycles in RESP -> `rsp_valid` and payload stable, `req_ready` stays 0, and the pending requester 1 is not granted.
- Assert `reset` during EXEC -> next cycle in IDLE with `rsp_valid=0`, and no response is ever issued for that operation.
- Back-to-back requests from requester 1 only, with `rsp_ready=1` -> accepts exactly every 3 cycles. Round-robin with only one requester active keeps granting it.
- With `ALU128_ARB_STICKY_EN` defined: overflowing add from requester 1 (op1=op2=128'h7FFF…FFFF) -> `sticky_ovf=2'b10`. Pulse `sticky_clr[1]` -> cleared. Clear coinciding with a new overflow response -> bit remains set.
